// File: rtl/regfile_sb.sv
// regfile_sb: multi-read-port register file (x0 = 0) with per-register pending-writer scoreboard.
// Defining RF_WB_BYPASS_EN adds same-cycle writeback-to-read bypass.
module regfile_sb #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned NUM_RD = 2,
    parameter int unsigned CNT_W  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     iss_valid,
    input  logic [ADDR_W-1:0]        iss_addr,
    output logic                     iss_ready,
    input  logic                     wb_we,
    input  logic [ADDR_W-1:0]        wb_addr,
    input  logic [DATA_W-1:0]        wb_data,
    input  logic                     wb_release,
    input  logic                     flush,
    output logic                     pend_any
);
    localparam int unsigned Depth = 2 ** ADDR_W;
    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    logic [DATA_W-1:0] regs_q [Depth];
    logic [CNT_W-1:0]  cnt_q  [Depth];
    logic [CNT_W-1:0]  cnt_d  [Depth];
    logic              wb_live;
    logic              fire;
    logic              rel;

    assign wb_live = wb_we && (wb_addr != '0);
    assign rel     = wb_live && wb_release;

    // A full counter can still accept a new writer if its last one retires this cycle.
    assign iss_ready = !((iss_addr != '0) && (cnt_q[iss_addr] == CntMax) &&
                         !(rel && (wb_addr == iss_addr)));
    assign fire = iss_valid && iss_ready && (iss_addr != '0);

    always_comb begin
        cnt_d[0] = '0;
        for (int unsigned j = 1; j < Depth; j++) begin
            logic inc;
            logic dec;
            inc = fire && (iss_addr == ADDR_W'(j));
            dec = rel && (wb_addr == ADDR_W'(j));
            if (flush) begin
                cnt_d[j] = inc ? CntOne : '0;
            end else if (inc && !dec) begin
                cnt_d[j] = cnt_q[j] + CntOne;
            end else if (dec && !inc && (cnt_q[j] != '0)) begin
                cnt_d[j] = cnt_q[j] - CntOne;
            end else begin
                cnt_d[j] = cnt_q[j];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned j = 0; j < Depth; j++) begin
                regs_q[j] <= '0;
                cnt_q[j]  <= '0;
            end
        end else begin
            if (wb_live) begin
                regs_q[wb_addr] <= wb_data;
            end
            for (int unsigned j = 0; j < Depth; j++) begin
                cnt_q[j] <= cnt_d[j];
            end
        end
    end

    always_comb begin
        pend_any = 1'b0;
        for (int unsigned j = 0; j < Depth; j++) begin
            pend_any = pend_any | (cnt_q[j] != '0);
        end
    end

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int unsigned i = 0; i < NUM_RD; i++) begin
            logic [ADDR_W-1:0] ra;
            logic [CNT_W-1:0]  cnt;
            logic              hit;
            ra  = rd_addr[i*ADDR_W +: ADDR_W];
            cnt = cnt_q[ra];
`ifdef RF_WB_BYPASS_EN
            hit = wb_live && (wb_addr == ra);
`else
            hit = 1'b0;
`endif
            if (ra == '0) begin
                rd_data[i*DATA_W +: DATA_W] = '0;
            end else if (hit) begin
                rd_data[i*DATA_W +: DATA_W] = wb_data;
            end else begin
                rd_data[i*DATA_W +: DATA_W] = regs_q[ra];
            end
            // The last outstanding writer completing through the bypass clears busy early.
            rd_busy[i] = (cnt != '0) && !(hit && wb_release && (cnt == CntOne));
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: expectations queued as stimulus is driven, drained at negedge.
module tb_regfile_sb;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NUM_RD = 2;
    localparam int CNT_W  = 2;
    localparam int DEPTH  = 32;
    localparam int CMAX   = 3;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic                     iss_valid;
    logic [ADDR_W-1:0]        iss_addr;
    logic                     iss_ready;
    logic                     wb_we;
    logic [ADDR_W-1:0]        wb_addr;
    logic [DATA_W-1:0]        wb_data;
    logic                     wb_release;
    logic                     flush;
    logic                     pend_any;

    regfile_sb #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .NUM_RD(NUM_RD),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_busy   (rd_busy),
        .iss_valid (iss_valid),
        .iss_addr  (iss_addr),
        .iss_ready (iss_ready),
        .wb_we     (wb_we),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .wb_release(wb_release),
        .flush     (flush),
        .pend_any  (pend_any)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] val;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] m_regs[DEPTH];
    int          m_cnt[DEPTH];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] dut_out(input int sel);
        case (sel)
            0: return rd_data[31:0];
            1: return rd_data[63:32];
            2: return {31'b0, rd_busy[0]};
            3: return {31'b0, rd_busy[1]};
            4: return {31'b0, iss_ready};
            default: return {31'b0, pend_any};
        endcase
    endfunction

    task automatic push_exp(input string tag, input int sel, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        sb_q.push_back(e);
    endtask

    function automatic logic m_rel();
        return wb_we && wb_release && (wb_addr != 0);
    endfunction

    function automatic logic [31:0] m_rd(input logic [ADDR_W-1:0] ra);
        if (ra == 0) return 32'h0;
`ifdef RF_WB_BYPASS_EN
        if (wb_we && wb_addr == ra) return wb_data;
`endif
        return m_regs[ra];
    endfunction

    function automatic logic m_busy(input logic [ADDR_W-1:0] ra);
`ifdef RF_WB_BYPASS_EN
        if (ra != 0 && wb_we && wb_addr == ra && wb_release && m_cnt[ra] == 1) return 1'b0;
`endif
        return m_cnt[ra] != 0;
    endfunction

    function automatic logic m_ready();
        if (iss_addr == 0) return 1'b1;
        if (m_cnt[iss_addr] == CMAX && !(m_rel() && wb_addr == iss_addr)) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic m_pend();
        for (int j = 0; j < DEPTH; j++) if (m_cnt[j] != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic clr_in();
        iss_valid  = 1'b0;
        wb_we      = 1'b0;
        wb_release = 1'b0;
        flush      = 1'b0;
    endtask

    task automatic set_rd(input int a0, input int a1);
        rd_addr = {ADDR_W'(a1), ADDR_W'(a0)};
    endtask

    // One clock: queue model expectations, compare at negedge, advance model at posedge.
    task automatic cycle();
        logic fire;
        logic rel;
        push_exp("rd_data0", 0, m_rd(rd_addr[4:0]));
        push_exp("rd_data1", 1, m_rd(rd_addr[9:5]));
        push_exp("rd_busy0", 2, {31'b0, m_busy(rd_addr[4:0])});
        push_exp("rd_busy1", 3, {31'b0, m_busy(rd_addr[9:5])});
        push_exp("iss_ready", 4, {31'b0, m_ready()});
        push_exp("pend_any", 5, {31'b0, m_pend()});
        fire = iss_valid && m_ready() && (iss_addr != 0);
        rel  = m_rel();
        @(negedge clk);
        while (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check(e.tag, dut_out(e.sel), e.val);
        end
        @(posedge clk);
        if (!rst) begin
            for (int j = 0; j < DEPTH; j++) begin
                m_regs[j] = 32'h0;
                m_cnt[j]  = 0;
            end
        end else begin
            if (wb_we && wb_addr != 0) m_regs[wb_addr] = wb_data;
            if (flush) begin
                for (int j = 0; j < DEPTH; j++) m_cnt[j] = 0;
                if (fire) m_cnt[iss_addr] = 1;
            end else if (!(fire && rel && iss_addr == wb_addr)) begin
                if (fire) m_cnt[iss_addr] = m_cnt[iss_addr] + 1;
                if (rel && m_cnt[wb_addr] > 0) m_cnt[wb_addr] = m_cnt[wb_addr] - 1;
            end
        end
        #1;
    endtask

    task automatic do_wb(input int a, input logic [31:0] d, input logic relf);
        wb_we = 1'b1; wb_addr = ADDR_W'(a); wb_data = d; wb_release = relf;
    endtask

    task automatic do_iss(input int a);
        iss_valid = 1'b1; iss_addr = ADDR_W'(a);
    endtask

    initial begin
        rst = 1'b0;
        clr_in();
        set_rd(0, 0);
        iss_addr = '0; wb_addr = '0; wb_data = '0;
        for (int j = 0; j < DEPTH; j++) begin
            m_regs[j] = 32'h0;
            m_cnt[j]  = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        // Random writes and reservations, then reset.
        for (int k = 0; k < 8; k++) begin
            clr_in();
            do_wb($urandom_range(1, 31), $urandom, 1'b0);
            do_iss($urandom_range(1, 31));
            set_rd($urandom_range(0, 31), $urandom_range(0, 31));
            cycle();
        end
        rst = 1'b0;
        cycle();
        rst = 1'b1;
        clr_in();
        set_rd(int'(wb_addr), int'(iss_addr));
        push_exp("rst_rd0", 0, 32'h0);
        push_exp("rst_rd1", 1, 32'h0);
        push_exp("rst_busy0", 2, 32'h0);
        push_exp("rst_pend", 5, 32'h0);
        push_exp("rst_ready", 4, 32'h1);
        cycle();

        // x0 protection.
        do_wb(0, 32'hDEADBEEF, 1'b1);
        set_rd(0, 0);
        cycle();
        clr_in();
        push_exp("x0_read", 0, 32'h0);
        do_iss(0);
        push_exp("x0_iss_ready", 4, 32'h1);
        cycle();
        clr_in();
        push_exp("x0_pend", 5, 32'h0);
        cycle();

        // Write/read with bypass.
        do_wb(5, 32'hAAAA0000, 1'b0);
        cycle();
        do_wb(5, 32'h12345678, 1'b0);
        set_rd(5, 0);
`ifdef RF_WB_BYPASS_EN
        push_exp("bypass_same", 0, 32'h12345678);
`else
        push_exp("nobypass_old", 0, 32'hAAAA0000);
`endif
        cycle();
        clr_in();
        push_exp("wr_next", 0, 32'h12345678);
        cycle();

        // Scoreboard saturation on x7.
        set_rd(7, 0);
        for (int k = 0; k < 3; k++) begin
            do_iss(7);
            cycle();
        end
        push_exp("sat_busy", 2, 32'h1);
        push_exp("sat_ready", 4, 32'h0);
        cycle();
        clr_in();
        iss_addr = ADDR_W'(7);
        do_wb(7, 32'h0000_0007, 1'b1);
        cycle();
        clr_in();
        push_exp("sat_rel_ready", 4, 32'h1);
        cycle();
        for (int k = 0; k < 2; k++) begin
            do_wb(7, 32'h0000_0070, 1'b1);
            cycle();
        end
        clr_in();
        push_exp("sat_clear_busy", 2, 32'h0);
        push_exp("sat_clear_pend", 5, 32'h0);
        cycle();

        // Simultaneous fire and release on x9, then flush with fire on x3.
        set_rd(9, 0);
        do_iss(9);
        cycle();
        do_iss(9);
        do_wb(9, 32'h9, 1'b1);
        cycle();
        clr_in();
        push_exp("x9_busy", 2, 32'h1);
        do_wb(9, 32'h99, 1'b1);
        cycle();
        clr_in();
        push_exp("x9_done", 2, 32'h0);
        do_iss(10);
        cycle();
        do_iss(3);
        flush = 1'b1;
        cycle();
        clr_in();
        set_rd(3, 10);
        push_exp("flush_x3", 2, 32'h1);
        push_exp("flush_x10", 3, 32'h0);
        push_exp("flush_pend", 5, 32'h1);
        cycle();

        // Reset mid-operation.
        flush = 1'b1;
        cycle();
        clr_in();
        do_iss(4); cycle();
        do_iss(4); cycle();
        do_iss(8); cycle();
        clr_in();
        set_rd(4, 8);
        rst = 1'b0;
        do_wb(4, 32'h55, 1'b1);
        cycle();
        rst = 1'b1;
        clr_in();
        push_exp("mid_rst_x4", 0, 32'h0);
        push_exp("mid_rst_b4", 2, 32'h0);
        push_exp("mid_rst_b8", 3, 32'h0);
        push_exp("mid_rst_pend", 5, 32'h0);
        cycle();

        // Random traffic concentrated on low registers.
        for (int k = 0; k < 400; k++) begin
            clr_in();
            set_rd($urandom_range(0, 7), $urandom_range(0, 31));
            iss_valid = ($urandom_range(0, 2) != 0);
            iss_addr  = ADDR_W'($urandom_range(0, 7));
            wb_we     = ($urandom_range(0, 1) != 0);
            wb_addr   = ADDR_W'($urandom_range(0, 7));
            wb_data   = $urandom;
            wb_release = ($urandom_range(0, 2) == 0);
            flush     = ($urandom_range(0, 31) == 0);
            rst       = ($urandom_range(0, 99) != 0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
